// File: rtl/dpll_ctrl_mlane.sv
// DPLL search-loop controller with N_LANES parallel BCP dispatch.
// Optional statistics counters are built when DPLL_STATS_EN is defined.
module dpll_ctrl_mlane #(
    parameter int VAR_BITS    = 8,
    parameter int CLAUSE_BITS = 10,
    parameter int N_LANES     = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [VAR_BITS-1:0]            num_vars,
    input  logic                           imp_empty,
    input  logic [VAR_BITS-1:0]            imp_var,
    input  logic                           imp_val,
    output logic                           imp_pop,
    output logic                           imp_flush,
    input  logic                           tr_empty,
    input  logic [VAR_BITS-1:0]            tr_var,
    input  logic                           tr_val,
    input  logic                           tr_type,
    output logic                           tr_push,
    output logic                           tr_pop,
    output logic [VAR_BITS-1:0]            tr_var_in,
    output logic                           tr_val_in,
    output logic                           tr_type_in,
    output logic [VAR_BITS-1:0]            vs_rd_var,
    input  logic                           vs_rd_unassigned,
    output logic                           vs_wr,
    output logic [VAR_BITS-1:0]            vs_var,
    output logic                           vs_val,
    output logic                           vs_unassign,
    output logic                           rng_rd,
    output logic [VAR_BITS-1:0]            rng_var,
    input  logic [CLAUSE_BITS-1:0]         rng_start,
    input  logic [CLAUSE_BITS-1:0]         rng_end,
    input  logic [N_LANES-1:0]             bcp_ready,
    input  logic [N_LANES-1:0]             bcp_busy,
    input  logic [N_LANES-1:0]             bcp_conflict,
    output logic [N_LANES-1:0]             bcp_valid,
    output logic [N_LANES*CLAUSE_BITS-1:0] bcp_clause,
    output logic                           bcp_clear,
    output logic                           sat,
    output logic                           unsat,
    output logic                           done,
    output logic [3:0]                     state_out,
    output logic [31:0]                    decision_cnt,
    output logic [31:0]                    conflict_cnt
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FIND      = 4'd1,
        S_SCAN      = 4'd2,
        S_RANGE     = 4'd3,
        S_DISPATCH  = 4'd4,
        S_DRAIN     = 4'd5,
        S_BACKTRACK = 4'd6,
        S_FLIP      = 4'd7,
        S_SAT       = 4'd8,
        S_UNSAT     = 4'd9
    } state_t;

    localparam logic [CLAUSE_BITS:0] C_ONE = 1;
    localparam logic [VAR_BITS:0]    V_ONE = 1;

    state_t                                r_state;
    logic [VAR_BITS:0]                     r_scan_ptr;
    logic [CLAUSE_BITS:0]                  r_ptr;
    logic [CLAUSE_BITS:0]                  r_end;
    logic                                  r_rng_wait;
    logic [VAR_BITS-1:0]                   r_bt_var;
    logic                                  r_bt_val;

    logic                                  r_imp_pop;
    logic                                  r_imp_flush;
    logic                                  r_tr_push;
    logic                                  r_tr_pop;
    logic [VAR_BITS-1:0]                   r_tr_var_in;
    logic                                  r_tr_val_in;
    logic                                  r_tr_type_in;
    logic                                  r_vs_wr;
    logic [VAR_BITS-1:0]                   r_vs_var;
    logic                                  r_vs_val;
    logic                                  r_vs_unassign;
    logic                                  r_rng_rd;
    logic [VAR_BITS-1:0]                   r_rng_var;
    logic [N_LANES-1:0]                    r_bcp_valid;
    logic [N_LANES-1:0][CLAUSE_BITS-1:0]   r_bcp_clause;
    logic                                  r_bcp_clear;
    logic                                  r_sat;
    logic                                  r_unsat;
    logic                                  r_done;

    logic [N_LANES-1:0]                    w_issue;
    logic [N_LANES-1:0][CLAUSE_BITS-1:0]   w_clause;
    logic [CLAUSE_BITS:0]                  w_next_ptr;
    logic                                  w_scan_end;

    // Ready lanes take consecutive clauses in ascending lane order until end.
    always_comb begin
        w_issue    = '0;
        w_clause   = '0;
        w_next_ptr = r_ptr;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if (bcp_ready[k] && (w_next_ptr < r_end)) begin
                w_issue[k]  = 1'b1;
                w_clause[k] = w_next_ptr[CLAUSE_BITS-1:0];
                w_next_ptr  = w_next_ptr + C_ONE;
            end
        end
    end

    assign w_scan_end = (r_scan_ptr >= {1'b0, num_vars});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_scan_ptr    <= '0;
            r_ptr         <= '0;
            r_end         <= '0;
            r_rng_wait    <= 1'b0;
            r_bt_var      <= '0;
            r_bt_val      <= 1'b0;
            r_imp_pop     <= 1'b0;
            r_imp_flush   <= 1'b0;
            r_tr_push     <= 1'b0;
            r_tr_pop      <= 1'b0;
            r_tr_var_in   <= '0;
            r_tr_val_in   <= 1'b0;
            r_tr_type_in  <= 1'b0;
            r_vs_wr       <= 1'b0;
            r_vs_var      <= '0;
            r_vs_val      <= 1'b0;
            r_vs_unassign <= 1'b0;
            r_rng_rd      <= 1'b0;
            r_rng_var     <= '0;
            r_bcp_valid   <= '0;
            r_bcp_clause  <= '0;
            r_bcp_clear   <= 1'b0;
            r_sat         <= 1'b0;
            r_unsat       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_imp_pop   <= 1'b0;
            r_imp_flush <= 1'b0;
            r_tr_push   <= 1'b0;
            r_tr_pop    <= 1'b0;
            r_vs_wr     <= 1'b0;
            r_rng_rd    <= 1'b0;
            r_bcp_valid <= '0;
            r_bcp_clear <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_scan_ptr <= '0;
                        r_state    <= S_FIND;
                    end
                end
                S_FIND: begin
                    if (!imp_empty) begin
                        r_imp_pop     <= 1'b1;
                        r_vs_wr       <= 1'b1;
                        r_vs_var      <= imp_var;
                        r_vs_val      <= imp_val;
                        r_vs_unassign <= 1'b0;
                        r_tr_push     <= 1'b1;
                        r_tr_var_in   <= imp_var;
                        r_tr_val_in   <= imp_val;
                        r_tr_type_in  <= 1'b1;
                        r_rng_rd      <= 1'b1;
                        r_rng_var     <= imp_var;
                        r_rng_wait    <= 1'b1;
                        r_state       <= S_RANGE;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_scan_end) begin
                        r_sat   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_SAT;
                    end else if (vs_rd_unassigned) begin
                        r_vs_wr       <= 1'b1;
                        r_vs_var      <= r_scan_ptr[VAR_BITS-1:0];
                        r_vs_val      <= 1'b0;
                        r_vs_unassign <= 1'b0;
                        r_tr_push     <= 1'b1;
                        r_tr_var_in   <= r_scan_ptr[VAR_BITS-1:0];
                        r_tr_val_in   <= 1'b0;
                        r_tr_type_in  <= 1'b0;
                        r_rng_rd      <= 1'b1;
                        r_rng_var     <= r_scan_ptr[VAR_BITS-1:0];
                        r_rng_wait    <= 1'b1;
                        r_state       <= S_RANGE;
                    end else begin
                        r_scan_ptr <= r_scan_ptr + V_ONE;
                    end
                end
                // First cycle carries the registered rng_rd; table data arrives the next.
                S_RANGE: begin
                    if (r_rng_wait) begin
                        r_rng_wait <= 1'b0;
                    end else begin
                        r_ptr <= {1'b0, rng_start};
                        r_end <= {1'b0, rng_end};
                        r_state <= (rng_start >= rng_end) ? S_DRAIN : S_DISPATCH;
                    end
                end
                S_DISPATCH, S_DRAIN: begin
                    if (|bcp_conflict) begin
                        r_bcp_clear <= 1'b1;
                        r_imp_flush <= 1'b1;
                        r_scan_ptr  <= '0;
                        r_state     <= S_BACKTRACK;
                    end else if (r_state == S_DISPATCH) begin
                        r_bcp_valid  <= w_issue;
                        r_bcp_clause <= w_clause;
                        r_ptr        <= w_next_ptr;
                        if (w_next_ptr == r_end)
                            r_state <= S_DRAIN;
                    end else if ((bcp_busy == '0) && (r_bcp_valid == '0)) begin
                        r_state <= S_FIND;
                    end
                end
                // A pop in flight leaves the stack top stale for one cycle.
                S_BACKTRACK: begin
                    if (!r_tr_pop) begin
                        if (tr_empty) begin
                            r_unsat <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_UNSAT;
                        end else if (tr_type) begin
                            r_tr_pop      <= 1'b1;
                            r_vs_wr       <= 1'b1;
                            r_vs_var      <= tr_var;
                            r_vs_val      <= 1'b0;
                            r_vs_unassign <= 1'b1;
                        end else begin
                            r_tr_pop      <= 1'b1;
                            r_vs_wr       <= 1'b1;
                            r_vs_var      <= tr_var;
                            r_vs_val      <= ~tr_val;
                            r_vs_unassign <= 1'b0;
                            r_bt_var      <= tr_var;
                            r_bt_val      <= tr_val;
                            r_state       <= S_FLIP;
                        end
                    end
                end
                S_FLIP: begin
                    r_tr_push    <= 1'b1;
                    r_tr_var_in  <= r_bt_var;
                    r_tr_val_in  <= ~r_bt_val;
                    r_tr_type_in <= 1'b1;
                    r_rng_rd     <= 1'b1;
                    r_rng_var    <= r_bt_var;
                    r_rng_wait   <= 1'b1;
                    r_state      <= S_RANGE;
                end
                S_SAT, S_UNSAT: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DPLL_STATS_EN
    logic [31:0] r_decision_cnt;
    logic [31:0] r_conflict_cnt;
    logic        w_dec_evt;
    logic        w_conf_evt;

    assign w_dec_evt  = (r_state == S_SCAN) && !w_scan_end && vs_rd_unassigned;
    assign w_conf_evt = ((r_state == S_DISPATCH) || (r_state == S_DRAIN)) && (|bcp_conflict);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_decision_cnt <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_dec_evt && (r_decision_cnt != '1))
                r_decision_cnt <= r_decision_cnt + 32'd1;
            if (w_conf_evt && (r_conflict_cnt != '1))
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign decision_cnt = r_decision_cnt;
    assign conflict_cnt = r_conflict_cnt;
`else
    assign decision_cnt = '0;
    assign conflict_cnt = '0;
`endif

    assign imp_pop     = r_imp_pop;
    assign imp_flush   = r_imp_flush;
    assign tr_push     = r_tr_push;
    assign tr_pop      = r_tr_pop;
    assign tr_var_in   = r_tr_var_in;
    assign tr_val_in   = r_tr_val_in;
    assign tr_type_in  = r_tr_type_in;
    assign vs_rd_var   = r_scan_ptr[VAR_BITS-1:0];
    assign vs_wr       = r_vs_wr;
    assign vs_var      = r_vs_var;
    assign vs_val      = r_vs_val;
    assign vs_unassign = r_vs_unassign;
    assign rng_rd      = r_rng_rd;
    assign rng_var     = r_rng_var;
    assign bcp_valid   = r_bcp_valid;
    assign bcp_clause  = r_bcp_clause;
    assign bcp_clear   = r_bcp_clear;
    assign sat         = r_sat;
    assign unsat       = r_unsat;
    assign done        = r_done;
    assign state_out   = r_state;

endmodule

// File: doc/dpll_ctrl_mlane.md
Name: dpll_ctrl_mlane

Overview:
- Parametrised DPLL solver control FSM. Sequences the search loop: implication drain, decision scan, clause-range fetch, BCP dispatch, chronological backtrack and SAT/UNSAT report.
- Generalises the single-lane controller in two ways. Clause dispatch runs across N_LANES parallel BCP engines, up to N_LANES clauses per cycle. Variable and clause widths are parameters.
- Sits between the implication queue, trace stack, variable-state table, var start/end table and the BCP lane array.

Parameters:
VAR_BITS, 8, variable index width
CLAUSE_BITS, 10, clause index width
N_LANES, 2, number of BCP lanes (>=1)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  begin solve; sampled only in IDLE
num_vars  in  VAR_BITS  variable count; vars are 0..num_vars-1
imp_empty  in  1  implication queue empty
imp_var  in  VAR_BITS  queue head var; valid when !imp_empty
imp_val  in  1  queue head value
imp_pop  out  1  pop head, 1-cycle pulse
imp_flush  out  1  clear queue, 1-cycle pulse
tr_empty  in  1  trace stack empty
tr_var  in  VAR_BITS  trace top var; valid when !tr_empty
tr_val  in  1  trace top value
tr_type  in  1  trace top type: 0 = decision, 1 = implied/flipped
tr_push  out  1  push pulse
tr_pop  out  1  pop pulse
tr_var_in  out  VAR_BITS  push var
tr_val_in  out  1  push value
tr_type_in  out  1  push type
vs_rd_var  out  VAR_BITS  var-state async read address
vs_rd_unassigned  in  1  read data, same cycle
vs_wr  out  1  var-state write pulse
vs_var  out  VAR_BITS  write var
vs_val  out  1  write value
vs_unassign  out  1  write unassigned flag
rng_rd  out  1  range read pulse
rng_var  out  VAR_BITS  range read var
rng_start  in  CLAUSE_BITS  first clause; valid the cycle after rng_rd
rng_end  in  CLAUSE_BITS  one past last clause; same timing
bcp_ready  in  N_LANES  lane k accepts a clause
bcp_busy  in  N_LANES  lane k evaluating
bcp_conflict  in  N_LANES  lane k found a conflict
bcp_valid  out  N_LANES  lane k dispatch strobe
bcp_clause  out  N_LANES*CLAUSE_BITS  lane k index at bits [k*CLAUSE_BITS +: CLAUSE_BITS]
bcp_clear  out  1  clear all lanes, 1-cycle pulse
sat  out  1  satisfiable, sticky
unsat  out  1  unsatisfiable, sticky
done  out  1  sat|unsat
state_out  out  4  current state encoding
decision_cnt  out  32  decisions made (optional feature)
conflict_cnt  out  32  conflicts seen (optional feature)

Behaviour:
- Reset:
  - All outputs 0; state IDLE; scan_ptr 0.
  - Reset mid-solve aborts immediately; no flush pulses are issued.
- All strobes (imp_pop, imp_flush, tr_push, tr_pop, vs_wr, rng_rd, bcp_valid, bcp_clear) are registered single-cycle pulses.
- State encodings: IDLE=0, FIND=1, SCAN=2, RANGE=3, DISPATCH=4, DRAIN=5, BACKTRACK=6, FLIP=7, SAT=8, UNSAT=9.
- IDLE: start -> FIND; scan_ptr=0.
- FIND:
  - !imp_empty: imp_pop, and vs_wr (imp_var, imp_val, unassign=0).
  - Same cycle: tr_push (imp_var, imp_val, type 1) and rng_rd (imp_var).
  - Then -> RANGE.
  - imp_empty: -> SCAN.
- SCAN:
  - vs_rd_var=scan_ptr.
  - If scan_ptr>=num_vars: -> SAT.
  - Else if vs_rd_unassigned: decide value 0. Issue vs_wr, tr_push (type 0) and rng_rd, then -> RANGE.
  - Else scan_ptr+=1; one var per cycle.
- RANGE: latch ptr=rng_start and end=rng_end. If rng_start>=rng_end -> DRAIN; else -> DISPATCH.
- DISPATCH:
  - Each cycle, scan lanes in ascending index. Each ready lane gets the next clause: ptr, ptr+1, ...
  - Stop at end; ptr advances by the number of lanes issued.
  - When ptr reaches end -> DRAIN.
  - A lane issued this cycle is not reused until its next bcp_ready.
- DRAIN: when bcp_busy==0 and no bcp_valid is pending -> FIND.
- Conflict:
  - Any bcp_conflict bit in DISPATCH or DRAIN (checked before completion) -> pulse bcp_clear and imp_flush.
  - Stop dispatch; scan_ptr=0; -> BACKTRACK.
  - Conflict has priority over completion.
  - bcp_conflict in any other state is ignored.
- BACKTRACK (stack top updates the cycle after tr_pop; one action per cycle):
  - tr_empty -> UNSAT.
  - tr_type==1: tr_pop, and vs_wr (tr_var, unassign=1). Stay in BACKTRACK.
  - tr_type==0: tr_pop, and vs_wr (tr_var, ~tr_val, unassign=0). Latch var/value, then -> FLIP.
- FLIP: tr_push (latched var, ~val, type 1) and rng_rd (latched var); -> RANGE.
- SAT/UNSAT: terminal until reset. sat/unsat and done held high; start ignored.
- Widths: ptr arithmetic is CLAUSE_BITS+1 wide, so rng_end at the maximum index does not wrap. scan_ptr is VAR_BITS+1 wide.

Optional Feature:
- Macro DPLL_STATS_EN.
- Defined: decision_cnt increments on each SCAN decision. conflict_cnt increments on each conflict entry to BACKTRACK. Both are 32-bit, saturating, and cleared by reset.
- Undefined: both ports are present but tied to 0, and no counter logic is built.

Test Plan:
1. num_vars=0, start -> SAT within 3 cycles, done=1, no tr_push.
2. num_vars=2, all ranges empty, all vars unassigned -> tr_push (0,0,type0) then (1,0,type0); SAT.
3. Imply queue holds (3,1) at start -> first tr_push is (3,1,type1) with imp_pop pulse; SCAN follows only after the queue is empty.
4. N_LANES=2, range [4,9), all lanes ready -> lane dispatch pairs 4/5, 6/7, then 8 on lane 0 only; 3 DISPATCH cycles.
5. Trace [var0 d val0, var2 type1], conflict on lane 1 -> bcp_clear and imp_flush; var2 unassigned; var0 written 1; tr_push (0,1,type1).
6. Trace holds only type-1 entries, conflict -> pops each, unassigning, until tr_empty; then unsat=1 sticky.
